conv_encoder_param: RTL
=======================

// Module: conv_encoder_param
// PURPOSE
//   Parametrised rate-1/N feed-forward convolutional encoder: constraint length, generators, symbol width.
//   Accepts serial info bits with valid/ready and registers one N-bit code symbol per accepted bit.
//   Zero-terminates each frame with K-1 tail bits after in_last. Sits between bit source and modulator/Viterbi link.
// PARAMETERS
//   K          3        constraint length (>=2); shift register holds K-1 past bits
//   N          2        code symbols per info bit (>=2)
//   G          6'o75    packed generators {g_(N-1),...,g_0}, K bits each; default g1=111, g0=101
//   PUNCT_P    2        puncture period in symbols (used only with PUNCTURE_EN)
//   PUNCT_PAT  4'b0111  packed masks {m_(P-1),...,m_0}, N bits each; no mask may be all-zero
// PORTS
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_bit     in   1    info bit
//   in_valid   in   1    in_bit valid
//   in_last    in   1    qualifies in_bit as last info bit of frame
//   in_ready   out  1    encoder accepts in_bit this cycle
//   out_sym    out  N    code symbol; out_sym[j] from generator g_j
//   out_mask   out  N    1 = out_sym bit transmitted; 0 = punctured
//   out_valid  out  1    out_sym/out_mask/out_last valid
//   out_last   out  1    symbol is final tail symbol of frame
//   out_ready  in   1    downstream accepts symbol
// BEHAVIOUR
//   Reset (async on rst_n low): regs=0, state=DATA, flush_cnt=0, punct_idx=0,
//     out_valid=0, out_last=0, out_sym=0, out_mask=all-ones; in_ready=0 while rst_n low.
//   Encoding: s = {u, regs[K-2:0]} (regs[K-2] newest); out_sym[j] = ^(g_j & s); regs <= s[K-1:1].
//   Output slot free when !out_valid || out_ready; slot free + new symbol -> load, out_valid=1.
//   in_ready = (state==DATA) && slot free (combinational from out_ready). Accept = in_valid && in_ready.
//   Latency: accepted bit -> out_valid next cycle. Full throughput: 1 symbol/cycle with out_ready=1.
//   States:
//     DATA:  on accept, encode u=in_bit; if in_last -> FLUSH, flush_cnt=K-1. Not accepting -> no change.
//     FLUSH: in_ready=0; each cycle slot free encode u=0, flush_cnt--; on the tail with flush_cnt==1
//            set out_last=1, clear punct_idx, state -> DATA (regs then all-zero).
//   Back-to-back frames: first bit of next frame acceptable the cycle after final tail is loaded.
//   Stall: out_ready=0 with out_valid=1 -> out_sym/out_mask/out_last held stable, regs frozen, no bit lost.
//   in_bit/in_last ignored when in_valid=0; in_last with in_ready=0 has no effect.
//   Reset mid-frame or mid-flush: partial frame discarded, state DATA, next frame starts from regs=0.
//   Elaboration error if K<2, N<2, or any puncture mask all-zero.
// CONFIGURATION
//   PUNCTURE_EN defined: out_mask = PUNCT_PAT[punct_idx*N +: N]; punct_idx increments mod PUNCT_P
//     per loaded symbol (tails included), reset to 0 at frame end and reset.
//   PUNCTURE_EN undefined: out_mask tied all-ones; PUNCT_P/PUNCT_PAT ignored; no punct_idx logic.
//   Encoding, handshake and timing identical in both builds.
// TESTING (defaults K=3, N=2, G=6'o75; symbols shown {out_sym[1],out_sym[0]})
//   Reset: rst_n=0 -> out_valid=0, in_ready=0, out_mask=11; release -> in_ready=1 next cycle.
//   Frame 1,0,1,1(last), out_ready=1 -> symbols 11,10,00,01,01,11; out_last only on 6th; in_ready=0 2 cycles.
//   Same frame, out_ready=0 for 3 cycles after 2nd symbol -> 10 held 3 cycles, in_ready=0, sequence unchanged.
//   Two frames back-to-back (1,1(last) then 1(last)) -> 11,01,01,11, 11,10,11; regs=0 between frames.
//   rst_n pulsed low during FLUSH -> out_valid=0 immediately; next frame 1(last) -> 11,10,11.
//   PUNCTURE_EN, frame 1,0,1,1(last) -> out_mask 11,01,11,01,11,01; symbols as unpunctured case.

Source files
------------

// File: rtl/conv_encoder_param.sv
// Rate-1/N feed-forward convolutional encoder with valid/ready handshake and zero-tail termination.
// Optional puncturing mask output is enabled by defining PUNCTURE_EN.
module conv_encoder_param #(
    parameter int                     K         = 3,
    parameter int                     N         = 2,
    parameter logic [K*N-1:0]         G         = 6'o75,
    parameter int                     PUNCT_P   = 2,
    parameter logic [PUNCT_P*N-1:0]   PUNCT_PAT = 4'b0111
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_bit,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [N-1:0] out_sym,
    output logic [N-1:0] out_mask,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready
);

    localparam int FCW = $clog2(K);

    generate
        if (K < 2) begin : g_bad_k
            $error("conv_encoder_param: K must be >= 2");
        end
        if (N < 2) begin : g_bad_n
            $error("conv_encoder_param: N must be >= 2");
        end
        for (genvar p = 0; p < PUNCT_P; p++) begin : g_pchk
            if (PUNCT_PAT[p*N +: N] == '0) begin : g_bad_mask
                $error("conv_encoder_param: puncture mask must not be all-zero");
            end
        end
    endgenerate

    typedef enum logic {ST_DATA, ST_FLUSH} state_t;

    state_t         state_q, state_d;
    logic [K-2:0]   regs_q, regs_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic [N-1:0]   out_sym_q, out_sym_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;

    logic           slot_free;
    logic           load;
    logic           tail_end;
    logic           u;
    logic [K-1:0]   s;

    function automatic logic [N-1:0] encode(input logic [K-1:0] sv);
        logic [N-1:0] r;
        for (int j = 0; j < N; j++) begin
            r[j] = ^(G[j*K +: K] & sv);
        end
        return r;
    endfunction

    assign slot_free = !out_valid_q || out_ready;
    // Gated by rst_n so upstream never sees ready while the encoder is held in reset.
    assign in_ready  = rst_n && (state_q == ST_DATA) && slot_free;

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        flush_cnt_d = flush_cnt_q;
        out_sym_d   = out_sym_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        load        = 1'b0;
        tail_end    = 1'b0;
        u           = 1'b0;

        case (state_q)
            ST_DATA: begin
                if (in_valid && in_ready) begin
                    load = 1'b1;
                    u    = in_bit;
                    if (in_last) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FCW'(K-1);
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    load        = 1'b1;
                    flush_cnt_d = flush_cnt_q - 1'b1;
                    if (flush_cnt_q == FCW'(1)) begin
                        tail_end = 1'b1;
                        state_d  = ST_DATA;
                    end
                end
            end
            default: state_d = ST_DATA;
        endcase

        s = {u, regs_q};
        if (load) begin
            out_sym_d   = encode(s);
            out_valid_d = 1'b1;
            out_last_d  = tail_end;
            regs_d      = s[K-1:1];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_DATA;
            regs_q      <= '0;
            flush_cnt_q <= '0;
            out_sym_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            flush_cnt_q <= flush_cnt_d;
            out_sym_q   <= out_sym_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef PUNCTURE_EN
    localparam int PW = (PUNCT_P > 1) ? $clog2(PUNCT_P) : 1;

    logic [PW-1:0] punct_idx_q, punct_idx_d;
    logic [N-1:0]  out_mask_q, out_mask_d;

    // Pattern position restarts every frame so each frame punctures identically.
    always_comb begin
        punct_idx_d = punct_idx_q;
        out_mask_d  = out_mask_q;
        if (load) begin
            out_mask_d = PUNCT_PAT[int'(punct_idx_q)*N +: N];
            if (tail_end || punct_idx_q == PW'(PUNCT_P-1)) begin
                punct_idx_d = '0;
            end else begin
                punct_idx_d = punct_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            punct_idx_q <= '0;
            out_mask_q  <= '1;
        end else begin
            punct_idx_q <= punct_idx_d;
            out_mask_q  <= out_mask_d;
        end
    end

    assign out_mask = out_mask_q;
`else
    assign out_mask = '1;
`endif

    assign out_sym   = out_sym_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule
